// File: rtl/niu_sii_req_sender.sv
// NIU->SII DMA request sender: one-entry hold, OQ/BQ credit metering, header + 0/1/4 payload beats.
// Latency: request accepted at edge N is on the bus in cycle N+1. Backpressure: req_rdy low while hold is full and not launching.
module niu_sii_req_sender #(
    parameter int OQ_CREDITS = 16,
    parameter int BQ_CREDITS = 16
) (
    input  logic         iol2clk,
    input  logic         rst,
    input  logic         req_vld,
    output logic         req_rdy,
    input  logic [1:0]   req_type,
    input  logic         req_bypass,
    input  logic [127:0] req_hdr,
    input  logic [511:0] req_data,
    input  logic [63:0]  req_be,
    input  logic         sii_niu_oqdq,
    input  logic         sii_niu_bqdq,
    output logic         niu_sii_hdr_vld,
    output logic         niu_sii_reqbypass,
    output logic         niu_sii_datareq,
    output logic         niu_sii_datareq16,
    output logic [127:0] niu_sii_data,
    output logic [7:0]   niu_sii_parity,
    output logic [15:0]  niu_sii_be,
    output logic         credit_err
);
    localparam logic [4:0] OQ_INIT = 5'(OQ_CREDITS);
    localparam logic [4:0] BQ_INIT = 5'(BQ_CREDITS);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t       state;
    logic [1:0]   beat_cnt;
    logic [1:0]   cur_type;
    logic [511:0] cur_data;
    logic [63:0]  cur_be;

    logic         hold_vld;
    logic [1:0]   hold_type;
    logic         hold_bypass;
    logic [127:0] hold_hdr;
    logic [511:0] hold_data;
    logic [63:0]  hold_be;

    logic [4:0]   oq_cnt;
    logic [4:0]   bq_cnt;

    logic         cur_read;
    logic [1:0]   last_beat;
    logic         xfer_last;
    logic         credit_ok;
    logic         launch;
    logic [1:0]   pay_idx;
    logic [127:0] pay_data;
    logic [15:0]  pay_be;
    logic         oq_dec;
    logic         bq_dec;

    function automatic logic [7:0] lane_parity(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    assign cur_read  = (cur_type == 2'b00) || (cur_type == 2'b11);
    assign last_beat = (cur_type == 2'b01) ? 2'd3 : 2'd0;
    assign xfer_last = (state == HDR && cur_read) || (state == PAY && beat_cnt == last_beat);
    assign credit_ok = hold_bypass ? (bq_cnt != 5'd0) : (oq_cnt != 5'd0);
    // Launching on the last beat of a transfer keeps back-to-back requests bubble-free.
    assign launch    = hold_vld && credit_ok && (state == IDLE || xfer_last);
    assign req_rdy   = !hold_vld || launch;
    assign pay_idx   = (state == HDR) ? 2'd0 : beat_cnt + 2'd1;
    assign pay_data  = cur_data[{pay_idx, 7'b0} +: 128];
    assign pay_be    = cur_be[{pay_idx, 4'b0} +: 16];
    assign oq_dec    = launch && !hold_bypass;
    assign bq_dec    = launch && hold_bypass;

    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            hold_vld    <= 1'b0;
            hold_type   <= 2'b00;
            hold_bypass <= 1'b0;
            hold_hdr    <= '0;
            hold_data   <= '0;
            hold_be     <= '0;
        end else begin
            if (launch) hold_vld <= 1'b0;
            if (req_vld && req_rdy) begin
                hold_vld    <= 1'b1;
                hold_type   <= req_type;
                hold_bypass <= req_bypass;
                hold_hdr    <= req_hdr;
                hold_data   <= req_data;
                hold_be     <= req_be;
            end
        end
    end

    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            oq_cnt     <= OQ_INIT;
            bq_cnt     <= BQ_INIT;
            credit_err <= 1'b0;
        end else begin
            if (sii_niu_oqdq && !oq_dec) begin
                if (oq_cnt == OQ_INIT) credit_err <= 1'b1;
                else                   oq_cnt <= oq_cnt + 5'd1;
            end else if (oq_dec && !sii_niu_oqdq) begin
                oq_cnt <= oq_cnt - 5'd1;
            end
            if (sii_niu_bqdq && !bq_dec) begin
                if (bq_cnt == BQ_INIT) credit_err <= 1'b1;
                else                   bq_cnt <= bq_cnt + 5'd1;
            end else if (bq_dec && !sii_niu_bqdq) begin
                bq_cnt <= bq_cnt - 5'd1;
            end
        end
    end

    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            beat_cnt          <= 2'd0;
            cur_type          <= 2'b00;
            cur_data          <= '0;
            cur_be            <= '0;
            niu_sii_hdr_vld   <= 1'b0;
            niu_sii_reqbypass <= 1'b0;
            niu_sii_datareq   <= 1'b0;
            niu_sii_datareq16 <= 1'b0;
            niu_sii_data      <= '0;
            niu_sii_parity    <= '0;
            niu_sii_be        <= '0;
        end else begin
            niu_sii_hdr_vld   <= 1'b0;
            niu_sii_reqbypass <= 1'b0;
            niu_sii_datareq   <= 1'b0;
            niu_sii_datareq16 <= 1'b0;
            niu_sii_data      <= '0;
            niu_sii_parity    <= '0;
            niu_sii_be        <= '0;
            if (launch) begin
                state             <= HDR;
                beat_cnt          <= 2'd0;
                cur_type          <= hold_type;
                cur_data          <= hold_data;
                cur_be            <= hold_be;
                niu_sii_hdr_vld   <= 1'b1;
                niu_sii_reqbypass <= hold_bypass;
                niu_sii_datareq   <= (hold_type == 2'b01);
                niu_sii_datareq16 <= (hold_type == 2'b10);
                niu_sii_data      <= hold_hdr;
                niu_sii_parity    <= lane_parity(hold_hdr);
            end else begin
                case (state)
                    HDR: begin
                        if (cur_read) begin
                            state <= IDLE;
                        end else begin
                            state          <= PAY;
                            beat_cnt       <= 2'd0;
                            niu_sii_data   <= pay_data;
                            niu_sii_parity <= lane_parity(pay_data);
                            niu_sii_be     <= pay_be;
                        end
                    end
                    PAY: begin
                        if (beat_cnt == last_beat) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt       <= beat_cnt + 2'd1;
                            niu_sii_data   <= pay_data;
                            niu_sii_parity <= lane_parity(pay_data);
                            niu_sii_be     <= pay_be;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_niu_sii_req_sender.sv
// Bench for niu_sii_req_sender: beat-queue reference model checked every cycle, plus directed literal scenarios.
module tb_niu_sii_req_sender;
    logic         iol2clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_vld = 1'b0;
    logic         req_rdy;
    logic [1:0]   req_type = 2'b00;
    logic         req_bypass = 1'b0;
    logic [127:0] req_hdr = '0;
    logic [511:0] req_data = '0;
    logic [63:0]  req_be = '0;
    logic         sii_niu_oqdq = 1'b0;
    logic         sii_niu_bqdq = 1'b0;
    logic         niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16;
    logic [127:0] niu_sii_data;
    logic [7:0]   niu_sii_parity;
    logic [15:0]  niu_sii_be;
    logic         credit_err;

    always #5 iol2clk = ~iol2clk;

    niu_sii_req_sender dut (
        .iol2clk(iol2clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_type(req_type), .req_bypass(req_bypass), .req_hdr(req_hdr),
        .req_data(req_data), .req_be(req_be),
        .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq),
        .niu_sii_hdr_vld(niu_sii_hdr_vld), .niu_sii_reqbypass(niu_sii_reqbypass),
        .niu_sii_datareq(niu_sii_datareq), .niu_sii_datareq16(niu_sii_datareq16),
        .niu_sii_data(niu_sii_data), .niu_sii_parity(niu_sii_parity),
        .niu_sii_be(niu_sii_be), .credit_err(credit_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hdr_log[$];
    int dr16_log[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    // Reference model: queue of bus beats still to be driven, plus a one-entry hold and credit counts.
    typedef struct packed {
        logic hv, byp, dr, dr16;
        logic [127:0] d;
        logic [15:0] be;
    } beat_t;
    beat_t        bus[$];
    logic         mh_v, mh_byp;
    logic [1:0]   mh_t;
    logic [127:0] mh_hdr;
    logic [511:0] mh_d;
    logic [63:0]  mh_be;
    int           m_oq, m_bq;
    logic         m_err;

    function automatic bit m_credit();
        return mh_byp ? (m_bq > 0) : (m_oq > 0);
    endfunction

    task automatic m_reset();
        bus.delete();
        mh_v = 0; mh_byp = 0; mh_t = 0;
        m_oq = 16; m_bq = 16; m_err = 0;
    endtask

    task automatic m_step();
        bit launch, rdy_pre, dec_o, dec_b;
        beat_t b;
        int nb;
        launch  = mh_v && m_credit() && bus.size() <= 1;
        rdy_pre = !mh_v || launch;
        if (bus.size() > 0) void'(bus.pop_front());
        dec_o = launch && !mh_byp;
        dec_b = launch && mh_byp;
        if (launch) begin
            b = '0;
            b.hv = 1; b.byp = mh_byp; b.dr = (mh_t == 2'b01); b.dr16 = (mh_t == 2'b10); b.d = mh_hdr;
            bus.push_back(b);
            nb = (mh_t == 2'b01) ? 4 : (mh_t == 2'b10) ? 1 : 0;
            for (int k = 0; k < nb; k++) begin
                b = '0;
                b.d  = mh_d[128*k +: 128];
                b.be = mh_be[16*k +: 16];
                bus.push_back(b);
            end
            mh_v = 0;
        end
        if (sii_niu_oqdq && !dec_o) begin
            if (m_oq == 16) m_err = 1; else m_oq++;
        end else if (dec_o && !sii_niu_oqdq) m_oq--;
        if (sii_niu_bqdq && !dec_b) begin
            if (m_bq == 16) m_err = 1; else m_bq++;
        end else if (dec_b && !sii_niu_bqdq) m_bq--;
        if (req_vld && rdy_pre) begin
            mh_v = 1; mh_t = req_type; mh_byp = req_bypass;
            mh_hdr = req_hdr; mh_d = req_data; mh_be = req_be;
        end
    endtask

    initial begin
        beat_t e;
        m_reset();
        forever begin
            @(posedge iol2clk);
            cyc++;
            if (rst) m_reset();
            else m_step();
            #1;
            e = (bus.size() > 0) ? bus[0] : '0;
            chk("bus_ctl", {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16},
                {e.hv, e.byp, e.dr, e.dr16});
            chk("bus_data", niu_sii_data, e.d);
            chk("bus_parity", niu_sii_parity, ref_par(e.d));
            chk("bus_be", niu_sii_be, e.be);
            chk("req_rdy", req_rdy, !mh_v || (m_credit() && bus.size() <= 1));
            chk("credit_err", credit_err, m_err);
            chk("oq_cnt", dut.oq_cnt, m_oq);
            chk("bq_cnt", dut.bq_cnt, m_bq);
            if (niu_sii_hdr_vld) hdr_log.push_back(cyc);
            if (niu_sii_datareq16) dr16_log.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge iol2clk);
        rst = 1'b1;
        @(negedge iol2clk);
        rst = 1'b0;
        hdr_log.delete();
        dr16_log.delete();
    endtask

    // Called at a negedge; returns at a negedge with acc = the cycle number of the accepting edge.
    task automatic send(input logic [1:0] t, input logic byp, input logic [127:0] h,
                        input logic [511:0] d, input logic [63:0] be, output int acc);
        int b;
        req_type = t; req_bypass = byp; req_hdr = h; req_data = d; req_be = be;
        req_vld = 1'b1;
        b = 0;
        while (!req_rdy && b < 200) begin
            @(negedge iol2clk);
            b++;
        end
        if (b >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: req_rdy stayed %0b for %0d cycles, required 1", req_rdy, b);
        end
        @(posedge iol2clk);
        #2 acc = cyc;
        @(negedge iol2clk);
        req_vld = 1'b0;
    endtask

    localparam logic [127:0] BA = {8{16'h0001}};
    localparam logic [127:0] BB = 128'h0;
    localparam logic [127:0] BC = {8{16'h0003}};
    localparam logic [127:0] BD = {8{16'h8000}};

    initial begin
        int acc, a1, a2, c0;
        logic took;
        logic [127:0] beats[4];
        logic [7:0]   pars[4];
        beats[0] = BA; beats[1] = BB; beats[2] = BC; beats[3] = BD;
        pars[0] = 8'hFF; pars[1] = 8'h00; pars[2] = 8'h00; pars[3] = 8'hFF;

        repeat (2) @(negedge iol2clk);
        rst = 1'b0;
        chk("rst_rdy", req_rdy, 1);
        chk("rst_hdr_vld", niu_sii_hdr_vld, 0);
        chk("rst_data", niu_sii_data, 0);
        chk("rst_err", credit_err, 0);
        chk("rst_oq", dut.oq_cnt, 16);
        chk("rst_bq", dut.bq_cnt, 16);

        // Single ordered read
        send(2'b00, 1'b0, 128'h1234, '0, '0, acc);
        @(negedge iol2clk);
        chk("rd_ctl", {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16}, 4'b1000);
        chk("rd_data", niu_sii_data, 128'h1234);
        chk("rd_hdr_cycle", hdr_log[0], acc + 1);
        chk("rd_oq", dut.oq_cnt, 15);

        // 64 B bypass write
        do_reset();
        send(2'b01, 1'b1, 128'hABCD, {BD, BC, BB, BA}, {4{16'hFFFF}}, acc);
        @(negedge iol2clk);
        chk("w64_ctl", {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16}, 4'b1110);
        chk("w64_be_hdr", niu_sii_be, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge iol2clk);
            chk("w64_beat_ctl", {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16}, 4'b0000);
            chk("w64_beat_data", niu_sii_data, beats[k]);
            chk("w64_beat_par", niu_sii_parity, pars[k]);
            chk("w64_beat_be", niu_sii_be, 16'hFFFF);
        end
        chk("w64_bq", dut.bq_cnt, 15);

        // Back-to-back read, 64 B write, 16 B write
        do_reset();
        send(2'b00, 1'b0, 128'h11, '0, '0, a1);
        send(2'b01, 1'b0, 128'h22, {4{128'h5A5A}}, {4{16'h0F0F}}, a2);
        send(2'b10, 1'b0, 128'h33, {384'h0, 128'h77}, {48'h0, 16'h00FF}, acc);
        repeat (10) @(negedge iol2clk);
        chk("b2b_hdr_count", hdr_log.size(), 3);
        chk("b2b_hdr0", hdr_log[0], a1 + 1);
        chk("b2b_hdr1", hdr_log[1], a1 + 2);
        chk("b2b_hdr2", hdr_log[2], a1 + 7);
        chk("b2b_dr16", dr16_log[0], a1 + 7);

        // Ordered credits exhausted, then one returned
        do_reset();
        for (int i = 0; i < 17; i++) send(2'b00, 1'b0, 128'(i), '0, '0, acc);
        repeat (3) @(negedge iol2clk);
        chk("starve_rdy", req_rdy, 0);
        chk("starve_oq", dut.oq_cnt, 0);
        chk("starve_hdr_count", hdr_log.size(), 16);
        c0 = cyc;
        sii_niu_oqdq = 1'b1;
        @(negedge iol2clk);
        sii_niu_oqdq = 1'b0;
        repeat (3) @(negedge iol2clk);
        chk("dq_hdr_count", hdr_log.size(), 17);
        chk("dq_hdr_cycle", hdr_log[16], c0 + 2);
        chk("dq_rdy", req_rdy, 1);

        // Credit return at max
        do_reset();
        sii_niu_oqdq = 1'b1;
        @(negedge iol2clk);
        sii_niu_oqdq = 1'b0;
        @(negedge iol2clk);
        chk("ovf_oq", dut.oq_cnt, 16);
        chk("ovf_err", credit_err, 1);
        repeat (3) @(negedge iol2clk);
        chk("ovf_err_sticky", credit_err, 1);

        // Reset during payload beat 2
        do_reset();
        send(2'b01, 1'b0, 128'h99, {BD, BC, BB, BA}, {4{16'hFFFF}}, acc);
        repeat (4) @(negedge iol2clk);
        chk("mid_beat2", niu_sii_data, BC);
        rst = 1'b1;
        #1;
        chk("mid_rst_ctl", {niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16}, 0);
        chk("mid_rst_data", {niu_sii_data, niu_sii_be, niu_sii_parity}, 0);
        @(negedge iol2clk);
        rst = 1'b0;
        #1;
        chk("mid_oq", dut.oq_cnt, 16);
        chk("mid_bq", dut.bq_cnt, 16);
        chk("mid_rdy", req_rdy, 1);

        // Randomized traffic with a reset in the middle
        took = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge iol2clk);
            if (took) req_vld = 1'b0;
            if (i == 1500) begin
                rst = 1'b1; req_vld = 1'b0; took = 1'b0;
                sii_niu_oqdq = 1'b0; sii_niu_bqdq = 1'b0;
                @(negedge iol2clk);
                rst = 1'b0;
            end
            sii_niu_oqdq = ($urandom_range(0, 3) == 0);
            sii_niu_bqdq = ($urandom_range(0, 3) == 0);
            if (!req_vld && $urandom_range(0, 2) != 0) begin
                req_type   = 2'($urandom_range(0, 3));
                req_bypass = 1'($urandom_range(0, 1));
                for (int k = 0; k < 4; k++) req_hdr[32*k +: 32] = $urandom;
                for (int k = 0; k < 16; k++) req_data[32*k +: 32] = $urandom;
                for (int k = 0; k < 2; k++) req_be[32*k +: 32] = $urandom;
                req_vld = 1'b1;
            end
            took = req_vld && req_rdy;
        end
        @(negedge iol2clk);
        req_vld = 1'b0; sii_niu_oqdq = 1'b0; sii_niu_bqdq = 1'b0;
        repeat (10) @(negedge iol2clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
